sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// SRAM controller: turns one 32-bit load/store from the pipeline into two
// 16-bit accesses on an asynchronous SRAM. Each half is held for
// SRAM_WAIT+1 cycles. The pipeline is frozen through ready while an access
// is in progress.
module sram_controller #(
    parameter int SRAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic [31:0] St_value,
    input  logic        Mem_W_EN,
    input  logic        Mem_R_EN,
    output logic [31:0] Mem_out,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_LO = 3'd1,
        WR_HI = 3'd2,
        RD_LO = 3'd3,
        RD_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    // The counter must be able to hold the value SRAM_WAIT.
    localparam int CW = (SRAM_WAIT > 0) ? $clog2(SRAM_WAIT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SRAM_WAIT);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [16:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   mem_q, mem_d;
    logic [17:0]   sram_addr_q, sram_addr_d;
    logic          we_n_q, we_n_d;
    logic          oe_n_q, oe_n_d;
    logic          dq_oe_q, dq_oe_d;
    logic [15:0]   dq_out_q, dq_out_d;
    logic          strobe_end_s;
    logic          unused_addr_s;

    // Only word-address bits reach the SRAM; higher bits wrap and byte bits are dropped.
    assign unused_addr_s = ^{Address[31:19], Address[1:0]};

    // Next-state, wait counter, request latching and read-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: begin
                if (Mem_W_EN) begin
                    state_d = WR_LO;
                    cnt_d   = {CW{1'b0}};
                    addr_d  = Address[18:2];
                    data_d  = St_value;
                end else if (Mem_R_EN) begin
                    state_d = RD_LO;
                    cnt_d   = {CW{1'b0}};
                    addr_d  = Address[18:2];
                    data_d  = St_value;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_LO, WR_HI, RD_LO, RD_HI: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = {CW{1'b0}};
                    case (state_q)
                        WR_LO:   state_d = WR_HI;
                        WR_HI:   state_d = DONE;
                        RD_LO: begin
                            state_d     = RD_HI;
                            mem_d[15:0] = SRAM_DQ;
                        end
                        RD_HI: begin
                            state_d      = DONE;
                            mem_d[31:16] = SRAM_DQ;
                        end
                        default: state_d = IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + CW'(1'b1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM pin values for the upcoming state, so the pins come straight from flops.
    always_comb begin
        sram_addr_d  = 18'd0;
        we_n_d       = 1'b1;
        oe_n_d       = 1'b1;
        dq_oe_d      = 1'b0;
        dq_out_d     = 16'd0;
        // With no wait cycles a half is a single cycle, so the strobe spans it
        // and the write lands on the edge that ends the half.
        if (SRAM_WAIT != 0) begin
            strobe_end_s = (cnt_d == CNT_LAST);
        end else begin
            strobe_end_s = 1'b0;
        end
        case (state_d)
            WR_LO: begin
                sram_addr_d = {addr_d, 1'b0};
                dq_oe_d     = 1'b1;
                dq_out_d    = data_d[15:0];
                we_n_d      = strobe_end_s;
            end
            WR_HI: begin
                sram_addr_d = {addr_d, 1'b1};
                dq_oe_d     = 1'b1;
                dq_out_d    = data_d[31:16];
                we_n_d      = strobe_end_s;
            end
            RD_LO: begin
                sram_addr_d = {addr_d, 1'b0};
                oe_n_d      = 1'b0;
            end
            RD_HI: begin
                sram_addr_d = {addr_d, 1'b1};
                oe_n_d      = 1'b0;
            end
            default: begin
                sram_addr_d = 18'd0;
            end
        endcase
    end

    // State and output registers; reset aborts any access immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            addr_q      <= 17'd0;
            data_q      <= 32'd0;
            mem_q       <= 32'd0;
            sram_addr_q <= 18'd0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mem_q       <= mem_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
        end
    end

    // A pending request in IDLE already freezes the pipeline.
    assign ready = (state_q == DONE) ||
                   ((state_q == IDLE) && !Mem_W_EN && !Mem_R_EN);

    assign Mem_out   = mem_q;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule
